// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// Holds the loader state encoding, the header length width, and the
// running-checksum helper used by the loader FSM.
package inst_loader_pkg;

  // Header carries a 16-bit big-endian word count.
  localparam int HDR_W = 16;

  typedef enum logic [2:0] {
    LD_LEN_HI = 3'd0,
    LD_LEN_LO = 3'd1,
    LD_DATA   = 3'd2,
    LD_CSUM   = 3'd3,
    LD_DONE   = 3'd4,
    LD_ERR    = 3'd5
  } ld_state_t;

  // Fold one stream byte into the running XOR checksum.
  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/inst_loader_word_assembler.sv
// Packs four stream bytes into one 32-bit instruction word.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr         - synchronous clear of the shift register and byte index
//   shift_en    - accept data as the next byte of the current word
//   data        - incoming byte
//   word        - word including the byte being presented this cycle
//   word_full   - high while the 4th byte of a word is being accepted
module inst_loader_word_assembler #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_full
);

  logic [31:0] sr;
  logic [1:0]  idx;

  // Combine the stored bytes with the byte on the input so the loader can
  // capture a complete word on the same edge that accepts its last byte.
  always_comb begin
    word = 32'd0;
    if (BIG_ENDIAN) begin
      word = {sr[23:0], data};
    end else begin
      word = {data, sr[31:8]};
    end
  end

  assign word_full = shift_en && (idx == 2'd3);

  // Shift register and byte index; the index wraps naturally after 4 bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= 32'd0;
      idx <= 2'd0;
    end else if (clr) begin
      sr  <= 32'd0;
      idx <= 2'd0;
    end else if (shift_en) begin
      sr  <= word;
      idx <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Boot-time writer for the CPU instruction memory.
// Consumes a byte stream (16-bit word count, program words, XOR checksum),
// writes assembled words from address 0 and releases the CPU reset only
// after the checksum over the data bytes matches.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_data/in_valid/in_ready - byte stream handshake
//   start                 - re-arm pulse, honoured in DONE or ERR only
//   imem_we/addr/wdata    - instruction-memory write port (one-cycle pulses)
//   cpu_rst_n             - registered active-low CPU reset
//   done, err             - load result flags
//   words_loaded          - words written in the current load
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [ADDR_W:0] WL_ONE = {{ADDR_W{1'b0}}, 1'b1};

  ld_state_t        state;
  logic [HDR_W-1:0] len;
  logic [7:0]       csum;
  logic             xfer;
  logic             rearm;
  logic             last_word;
  logic             word_full;
  logic [31:0]      word;
  logic [31:0]      len_next;
  logic [31:0]      cap;

  // Ready is a pure decode of the state: accept bytes until the load ends.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      LD_LEN_HI, LD_LEN_LO, LD_DATA, LD_CSUM: in_ready = 1'b1;
      default:                                in_ready = 1'b0;
    endcase
  end

  assign xfer      = in_valid && in_ready;
  assign rearm     = start && ((state == LD_DONE) || (state == LD_ERR));
  assign cap       = 32'd1 << ADDR_W;
  // Full length as it will be once the low header byte is taken.
  assign len_next  = {{(32 - HDR_W){1'b0}}, len[HDR_W-1:8], in_data};
  // The word completing now is the final one of the image.
  assign last_word = (32'(words_loaded) + 32'd1) == {{(32 - HDR_W){1'b0}}, len};

  inst_loader_word_assembler #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (rearm),
    .shift_en  (xfer && (state == LD_DATA)),
    .data      (in_data),
    .word      (word),
    .word_full (word_full)
  );

  // Loader FSM with registered write port, status flags and CPU reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LD_LEN_HI;
      len          <= '0;
      csum         <= 8'd0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'd0;
      cpu_rst_n    <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        LD_LEN_HI: begin
          if (xfer) begin
            len[HDR_W-1:8] <= in_data;
            state          <= LD_LEN_LO;
          end
        end
        LD_LEN_LO: begin
          if (xfer) begin
            len[7:0] <= in_data;
            if (len_next > cap) begin
              state <= LD_ERR;
              err   <= 1'b1;
            end else if (len_next == 32'd0) begin
              state <= LD_CSUM;
            end else begin
              state <= LD_DATA;
            end
          end
        end
        LD_DATA: begin
          if (xfer) begin
            csum <= csum_update(csum, in_data);
            if (word_full) begin
              // words_loaded doubles as the word index for the address.
              imem_we      <= 1'b1;
              imem_wdata   <= word;
              imem_addr    <= words_loaded[ADDR_W-1:0];
              words_loaded <= words_loaded + WL_ONE;
              if (last_word) begin
                state <= LD_CSUM;
              end
            end
          end
        end
        LD_CSUM: begin
          if (xfer) begin
            if (in_data == csum) begin
              state     <= LD_DONE;
              done      <= 1'b1;
              cpu_rst_n <= 1'b1;
            end else begin
              state <= LD_ERR;
              err   <= 1'b1;
            end
          end
        end
        LD_DONE, LD_ERR: begin
          if (start) begin
            state        <= LD_LEN_HI;
            len          <= '0;
            csum         <= 8'd0;
            cpu_rst_n    <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
          end
        end
        default: begin
          state <= LD_LEN_HI;
        end
      endcase
    end
  end

endmodule
